// File: rtl/risc_fetch_queue.sv
// risc_fetch_queue: instruction prefetch queue with a single-beat bus master.
// Bytes are fetched one per bus cycle into a small circular queue, and the
// consumer removes 0..2 bytes per cycle. A flush restarts fetching at a new
// address. If a bus cycle is outstanding when the flush arrives, its byte is
// thrown away when it returns.
module risc_fetch_queue #(
  parameter int                DATA_W     = 8,
  parameter int                ADDR_W     = 16,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [ADDR_W-1:0]          flush_addr,
  input  logic                       hold,
  input  logic [1:0]                 pop,
  output logic [DATA_W-1:0]          q_out0,
  output logic [DATA_W-1:0]          q_out1,
  output logic [$clog2(DEPTH+1)-1:0] q_count,
  output logic [ADDR_W-1:0]          q_pc,
  output logic                       bus_cycle,
  output logic                       bus_ifetch,
  output logic [ADDR_W-1:0]          bus_addr,
  input  logic                       bus_ready,
  input  logic [DATA_W-1:0]          bus_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t              state_r;
  logic [DATA_W-1:0]   mem_r [DEPTH];
  logic [PW-1:0]       head_r;
  logic [CW-1:0]       count_r;
  logic [ADDR_W-1:0]   fetch_addr_r;
  logic [ADDR_W-1:0]   q_pc_r;
  logic [ADDR_W-1:0]   bus_addr_r;
  logic                bus_cycle_r;
  logic [DATA_W-1:0]   q_out0_r;
  logic [DATA_W-1:0]   q_out1_r;

  logic [1:0]          pop_req_s;
  logic [CW-1:0]       pop_n_s;
  logic [CW-1:0]       avail_s;
  logic                accept_s;
  logic [CW-1:0]       cnt_next_s;
  logic                space_s;
  logic [PW-1:0]       head_next_s;
  logic [PW-1:0]       wr_idx_s;
  logic [PW-1:0]       idx1_s;
  logic [DATA_W-1:0]   q_out0_next_s;
  logic [DATA_W-1:0]   q_out1_next_s;

  // Pop saturation, occupancy after this cycle, space check and next head bytes.
  always_comb begin
    pop_req_s = (pop == 2'd3) ? 2'd2 : pop;
    if (CW'(pop_req_s) > count_r) begin
      pop_n_s = count_r;
    end else begin
      pop_n_s = CW'(pop_req_s);
    end
    avail_s     = count_r - pop_n_s;
    // A returning byte is only accepted when no flush is discarding it.
    accept_s    = (state_r == FETCH) && bus_ready && !flush;
    cnt_next_s  = avail_s + CW'(accept_s);
    // A new fetch needs a free slot after counting the byte that may arrive now.
    space_s     = (cnt_next_s < CW'(DEPTH));
    head_next_s = head_r + PW'(pop_n_s);
    wr_idx_s    = head_r + PW'(count_r);
    idx1_s      = head_next_s + PW'(1);
    if (accept_s && (wr_idx_s == head_next_s)) begin
      q_out0_next_s = bus_rdata;
    end else begin
      q_out0_next_s = mem_r[head_next_s];
    end
    if (accept_s && (wr_idx_s == idx1_s)) begin
      q_out1_next_s = bus_rdata;
    end else begin
      q_out1_next_s = mem_r[idx1_s];
    end
  end

  // Queue storage: write each accepted fetch byte at the tail.
  always_ff @(posedge clk) begin
    if (accept_s && !rst) begin
      mem_r[wr_idx_s] <= bus_rdata;
    end
  end

  // Fetch FSM together with queue pointers and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      bus_cycle_r  <= 1'b0;
      bus_addr_r   <= RESET_ADDR;
      fetch_addr_r <= RESET_ADDR;
      q_pc_r       <= RESET_ADDR;
      count_r      <= '0;
      head_r       <= '0;
      q_out0_r     <= '0;
      q_out1_r     <= '0;
    end else begin
      q_out0_r <= q_out0_next_s;
      q_out1_r <= q_out1_next_s;
      case (state_r)
        IDLE: begin
          if (flush) begin
            count_r      <= '0;
            q_pc_r       <= flush_addr;
            fetch_addr_r <= flush_addr;
          end else begin
            count_r <= avail_s;
            head_r  <= head_next_s;
            q_pc_r  <= q_pc_r + ADDR_W'(pop_n_s);
            if (!hold && space_s) begin
              state_r     <= FETCH;
              bus_cycle_r <= 1'b1;
              bus_addr_r  <= fetch_addr_r;
            end
          end
        end
        FETCH: begin
          if (flush) begin
            count_r      <= '0;
            q_pc_r       <= flush_addr;
            fetch_addr_r <= flush_addr;
            if (bus_ready) begin
              state_r     <= IDLE;
              bus_cycle_r <= 1'b0;
            end else begin
              // Bus cycle must still finish; hold it and drop its data later.
              state_r <= DISCARD;
            end
          end else begin
            count_r <= cnt_next_s;
            head_r  <= head_next_s;
            q_pc_r  <= q_pc_r + ADDR_W'(pop_n_s);
            if (bus_ready) begin
              fetch_addr_r <= fetch_addr_r + ADDR_W'(1);
              if (!hold && space_s) begin
                bus_addr_r <= fetch_addr_r + ADDR_W'(1);
              end else begin
                state_r     <= IDLE;
                bus_cycle_r <= 1'b0;
              end
            end
          end
        end
        DISCARD: begin
          if (flush) begin
            q_pc_r       <= flush_addr;
            fetch_addr_r <= flush_addr;
          end
          if (bus_ready) begin
            state_r     <= IDLE;
            bus_cycle_r <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          bus_cycle_r <= 1'b0;
        end
      endcase
    end
  end

  assign q_out0     = q_out0_r;
  assign q_out1     = q_out1_r;
  assign q_count    = count_r;
  assign q_pc       = q_pc_r;
  assign bus_cycle  = bus_cycle_r;
  assign bus_ifetch = bus_cycle_r;
  assign bus_addr   = bus_addr_r;

endmodule
